dmem_port_arbiter: RTL and testbench

// - Shares the single-port word data memory (dmem) between two requesters: port 0 = CPU load/store unit,

---
 rtl/dmem_ctrl_pkg.sv | 30 +++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/dmem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the dmem port arbiter.
// Holds the controller state encoding and byte-merge function.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RMW_WR = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    function automatic logic [31:0] merge_bytes(
        input logic [3:0]  wstrb,
        input logic [31:0] wdata,
        input logic [31:0] rdata
    );
        logic [31:0] m;
        m = rdata;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                m[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter, round-robin or fixed priority.
// Keeps track of which port was granted last.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       mode,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last;

    // one-hot grant; on a tie, fixed mode or port 1 last -> port 0
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (mode || last) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // pointer moves only when a transfer actually happens
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port word dmem between the LSU and debug DMA.
// Converts byte addresses and does read-modify-write for partial stores.
module dmem_port_arbiter
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 15,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_we,
    input  logic [1:0][31:0] req_addr,
    input  logic [1:0][31:0] req_wdata,
    input  logic [1:0][3:0]  req_wstrb,
    output logic [1:0]       rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             mem_is_load,
    output logic             mem_is_store,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_store_data,
    input  logic [31:0]      mem_load_data
);

    state_e      state;
    logic [1:0]  grant;
    logic        accept;
    logic        sel;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic [3:0]  sel_wstrb;
    logic        bad_addr;
    logic [31:0] word_idx;

    logic        port_q;
    logic        we_q;
    logic        rmw_q;
    logic        err_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (req_valid),
        .mode   (ARB_MODE == ARB_FIXED),
        .accept (accept),
        .grant  (grant)
    );

    // ready only while idle; a transfer is a granted valid port
    always_comb begin
        req_ready = (state == IDLE) ? grant : 2'b00;
        accept    = |(req_valid & req_ready);
        sel       = grant[1];
        sel_addr  = req_addr[sel];
        sel_we    = req_we[sel];
        sel_wstrb = req_wstrb[sel];
        bad_addr  = (sel_addr[1:0] != 2'b00)
                 || ((sel_addr >> (ADDR_W + 2)) != 32'd0);
        word_idx  = {{(32 - ADDR_W){1'b0}}, sel_addr[ADDR_W+1:2]};
    end

    // request FSM; dmem strobes and responses are single-cycle pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rsp_valid      <= 2'b00;
            rsp_rdata      <= 32'd0;
            rsp_err        <= 1'b0;
            mem_is_load    <= 1'b0;
            mem_is_store   <= 1'b0;
            mem_addr       <= 32'd0;
            mem_store_data <= 32'd0;
            port_q         <= 1'b0;
            we_q           <= 1'b0;
            rmw_q          <= 1'b0;
            err_q          <= 1'b0;
            wdata_q        <= 32'd0;
            wstrb_q        <= 4'd0;
        end else begin
            mem_is_load  <= 1'b0;
            mem_is_store <= 1'b0;
            rsp_valid    <= 2'b00;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        port_q   <= sel;
                        we_q     <= sel_we;
                        wdata_q  <= req_wdata[sel];
                        wstrb_q  <= sel_wstrb;
                        mem_addr <= word_idx;
                        rmw_q    <= 1'b0;
                        if (bad_addr) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end else if (sel_we && sel_wstrb == 4'h0) begin
                            err_q <= 1'b0;
                            state <= RESP;
                        end else if (!sel_we) begin
                            mem_is_load <= 1'b1;
                            state       <= ACCESS;
                        end else if (sel_wstrb == 4'hF) begin
                            mem_is_store   <= 1'b1;
                            mem_store_data <= req_wdata[sel];
                            state          <= ACCESS;
                        end else begin
                            mem_is_load <= 1'b1;
                            rmw_q       <= 1'b1;
                            state       <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (rmw_q) begin
                        mem_is_store   <= 1'b1;
                        mem_store_data <= merge_bytes(wstrb_q, wdata_q,
                                                      mem_load_data);
                        state          <= RMW_WR;
                    end else begin
                        rsp_valid <= port_q ? 2'b10 : 2'b01;
                        rsp_rdata <= we_q ? 32'd0 : mem_load_data;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                RMW_WR: begin
                    rsp_valid <= port_q ? 2'b10 : 2'b01;
                    rsp_rdata <= 32'd0;
                    rsp_err   <= 1'b0;
                    state     <= IDLE;
                end
                RESP: begin
                    rsp_valid <= port_q ? 2'b10 : 2'b01;
                    rsp_rdata <= 32'd0;
                    rsp_err   <= err_q;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed steps plus random requests.
// Expected results come from a word-array memory model and arbitration rules.
module tb_dmem_port_arbiter;

    localparam int AW = 15;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0][3:0]  req_wstrb;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             mem_is_load;
    logic             mem_is_store;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_store_data;
    logic [31:0]      mem_load_data;

    logic [1:0]       fx_ready;
    logic [1:0]       fx_rsp_valid;
    logic [31:0]      fx_rsp_rdata;
    logic             fx_rsp_err;
    logic             fx_is_load;
    logic             fx_is_store;
    logic [31:0]      fx_addr;
    logic [31:0]      fx_store_data;
    logic [31:0]      fx_load_data;

    int tests = 0;
    int fails = 0;
    int exp_last = 1;

    bit [31:0] mem     [0:(1<<AW)-1];
    bit [31:0] ref_mem [0:(1<<AW)-1];
    int        n_ld = 0;
    int        n_st = 0;
    int        n_both = 0;
    logic [31:0] last_addr = 32'd0;

    dmem_port_arbiter #(.ADDR_W(AW), .ARB_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
        .mem_addr(mem_addr), .mem_store_data(mem_store_data),
        .mem_load_data(mem_load_data)
    );

    dmem_port_arbiter #(.ADDR_W(AW), .ARB_MODE(1)) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(fx_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(fx_rsp_valid), .rsp_rdata(fx_rsp_rdata),
        .rsp_err(fx_rsp_err),
        .mem_is_load(fx_is_load), .mem_is_store(fx_is_store),
        .mem_addr(fx_addr), .mem_store_data(fx_store_data),
        .mem_load_data(fx_load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fx_load_data = 32'd0;

    // dmem model: samples strobes on the negedge between posedges
    always @(negedge clk) begin
        if (mem_is_load && mem_is_store) n_both <= n_both + 1;
        if (mem_is_load) begin
            mem_load_data <= mem[mem_addr[AW-1:0]];
            n_ld          <= n_ld + 1;
            last_addr     <= mem_addr;
        end
        if (mem_is_store) begin
            mem[mem_addr[AW-1:0]] <= mem_store_data;
            n_st                  <= n_st + 1;
            last_addr             <= mem_addr;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one request from one port, checked end to end against the model
    task automatic do_req(input int p, input bit we,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws);
        int          t;
        int          lat;
        int          idx;
        int          ld0;
        int          st0;
        bit          err;
        bit          acc_ld;
        bit          acc_st;
        logic [31:0] erd;
        logic [31:0] nv;
        logic [1:0]  oh;
        err    = (a % 4 != 0) || (a >= (32'd1 << (AW + 2)));
        idx    = int'(a / 4) % (1 << AW);
        oh     = (p == 1) ? 2'b10 : 2'b01;
        acc_ld = !err && (!we || (ws != 4'h0 && ws != 4'hF));
        acc_st = !err && we && ws != 4'h0;
        lat    = (acc_ld && acc_st) ? 2 : 1;
        erd    = (!err && !we) ? ref_mem[idx] : 32'd0;
        req_valid[p] = 1'b1;
        req_we[p]    = we;
        req_addr[p]  = a;
        req_wdata[p] = wd;
        req_wstrb[p] = ws;
        #1;
        t = 0;
        while (!req_ready[p] && t < 20) begin
            @(posedge clk); #1; t++;
        end
        chk("ready", {31'd0, req_ready[p]}, 32'd1);
        ld0 = n_ld;
        st0 = n_st;
        @(posedge clk); #1;
        exp_last     = p;
        req_valid[p] = 1'b0;
        req_addr[p]  = $urandom;
        req_wdata[p] = $urandom;
        req_wstrb[p] = 4'($urandom);
        req_we[p]    = 1'($urandom);
        chk("rsp_early", {30'd0, rsp_valid}, 32'd0);
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            if (c < lat) begin
                chk("rsp_wait", {30'd0, rsp_valid}, 32'd0);
            end else begin
                chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, oh});
                chk("rsp_rdata", rsp_rdata, erd);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, err});
            end
        end
        @(posedge clk); #1;
        chk("rsp_pulse", {30'd0, rsp_valid}, 32'd0);
        chk("n_loads", ld0 - n_ld < 0 ? n_ld - ld0 : 0, {31'd0, acc_ld});
        chk("n_stores", st0 - n_st < 0 ? n_st - st0 : 0, {31'd0, acc_st});
        if (acc_ld || acc_st) chk("mem_addr", last_addr, idx);
        if (acc_st) begin
            nv = ref_mem[idx];
            for (int b = 0; b < 4; b++) begin
                if (ws[b]) begin
                    nv = (nv & ~(32'hFF << (8 * b)))
                       | (wd & (32'hFF << (8 * b)));
                end
            end
            ref_mem[idx] = nv;
        end
        if (!err) chk("mem_word", mem[idx], ref_mem[idx]);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rsp"}, {30'd0, rsp_valid}, 32'd0);
        chk({tag, "_ld"}, {31'd0, mem_is_load}, 32'd0);
        chk({tag, "_st"}, {31'd0, mem_is_store}, 32'd0);
        chk({tag, "_ready"}, {30'd0, req_ready}, 32'd0);
    endtask

    initial begin
        int          t;
        int          e;
        int          st0;
        logic [3:0]  ws;
        logic [31:0] a;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        chk("reset_addr", mem_addr, 32'd0);
        chk("reset_sd", mem_store_data, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_err", {31'd0, rsp_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
        do_req(1, 1'b1, 32'h20, 32'h12345678, 4'hF);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0);
        do_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF);
        do_req(0, 1'b1, 32'h20, 32'h00001122, 4'h3);
        do_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
        chk("rmw_word", ref_mem[8], 32'hAABB1122);
        do_req(0, 1'b0, 32'h0000_0002, 32'h0, 4'h0);
        do_req(1, 1'b1, 32'h0002_0000, 32'hFFFFFFFF, 4'hF);
        do_req(1, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0);

        req_valid   = 2'b11;
        req_we      = 2'b00;
        req_addr[0] = 32'h10;
        req_addr[1] = 32'h20;
        #1;
        for (int i = 0; i < 6; i++) begin
            t = 0;
            while (req_ready == 2'b00 && t < 10) begin
                @(posedge clk); #1; t++;
            end
            e = (exp_last == 1) ? 0 : 1;
            chk("rr_grant", {30'd0, req_ready}, (e == 1) ? 2 : 1);
            chk("fx_grant", {30'd0, fx_ready}, 32'd1);
            exp_last = e;
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        ref_mem[12] = ref_mem[12];
        do_req(1, 1'b1, 32'h30, 32'h5566_7788, 4'hF);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h30;
        req_wdata[0] = 32'h0000_00EE;
        req_wstrb[0] = 4'h1;
        #1;
        t = 0;
        while (!req_ready[0] && t < 10) begin
            @(posedge clk); #1; t++;
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        st0 = n_st;
        @(posedge clk); #1;
        chk("rmw_wr_store", {31'd0, mem_is_store}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_store", {31'd0, mem_is_store}, 32'd0);
        chk("rst_load", {31'd0, mem_is_load}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_rsp", {30'd0, rsp_valid}, 32'd0);
        end
        chk("rst_no_write", n_st - st0, 32'd0);
        chk("rst_mem", mem[12], ref_mem[12]);
        rst_n    = 1'b1;
        exp_last = 1;
        @(posedge clk); #1;
        chk_idle("post_rst");

        for (int i = 0; i < 60; i++) begin
            a = {25'd0, 5'($urandom), 2'b00};
            if ($urandom_range(0, 9) == 0) a = a | 32'h1;
            if ($urandom_range(0, 9) == 0) a = a | (32'h1 << (19 + $urandom_range(0, 12)));
            case ($urandom_range(0, 3))
                0:       ws = 4'hF;
                1:       ws = 4'h0;
                default: ws = 4'($urandom);
            endcase
            do_req(int'($urandom_range(0, 1)), 1'($urandom), a, $urandom, ws);
        end

        chk("never_both", n_both, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
